serial_ripple_subtractor: RTL

SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

---
 rtl/serial_ripple_subtractor.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial A - B - Bin subtractor, one bit per clock, LSB first
// Result and flags are held until the consumer takes them; operands stay frozen while the operation runs.
module serial_ripple_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] Diff,
  output logic         Bout,
  output logic         Ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   res;
  logic           br;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   a_shr;
  logic [W-1:0]   b_shr;
  logic [W-1:0]   res_next;
  logic           a_bit;
  logic           b_bit;
  logic           d;
  logic           br_next;

  // Operands are never shifted in place; the current bit is selected by the counter.
  always_comb begin
    a_shr    = a_reg >> cnt;
    b_shr    = b_reg >> cnt;
    a_bit    = a_shr[0];
    b_bit    = b_shr[0];
    d        = a_bit ^ b_bit ^ br;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    res_next = (res >> 1) | (W'(d) << (W - 1));
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res       <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      Diff      <= '0;
      Bout      <= 1'b0;
      Ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
            br    <= Bin;
            cnt   <= '0;
            res   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res <= res_next;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          // On the MSB step, br is the borrow into bit W-1 and br_next the borrow out of it.
          if (cnt == CW'(W - 1)) begin
            Diff      <= res_next;
            Bout      <= br_next;
            Ovf       <= br ^ br_next;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
